// File: rtl/key_step_sel_pkg.sv
// Shared definitions for the key stepper: filter state encoding,
// 50 MHz default timing constants and a counter-width helper.
package key_step_pkg;

    // Debounce window: 20 ms at 50 MHz.
    localparam int CNT_FILT_50M = 999_999;
    // Auto-step period minus one: 0.5 s at 50 MHz.
    localparam int CNT_STEP_50M = 24_999_999;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILT_DN = 2'd1,
        HELD    = 2'd2,
        FILT_UP = 2'd3
    } filt_state_e;

    // Bits needed to hold 0..max_val; never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_step_sel_if.sv
// Signal bundle between the key stepper and its environment.
// There is no valid/ready handshake on this bundle: key_flag and step are
// single-cycle pulses with no back-pressure, a/b/c are a registered level
// index, and key_in/auto_en are free-running levels sampled every clock.
interface key_step_sel_if;
    logic       key_in;
    logic       auto_en;
    logic       a;
    logic       b;
    logic       c;
    logic       key_flag;
    logic       step;
    logic [1:0] filt_state;

    modport slave (
        input  key_in, auto_en,
        output a, b, c, key_flag, step, filt_state
    );

    modport master (
        output key_in, auto_en,
        input  a, b, c, key_flag, step, filt_state
    );
endinterface

// File: rtl/key_step_sel_filter.sv
// Reusable push-button debouncer: 2-flop synchroniser, 4-state filter FSM
// and a registered one-cycle key_flag per accepted press (active-low key).
module key_filter
    import key_step_pkg::*;
#(
    parameter int CNT_FILT = CNT_FILT_50M
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_in,
    output logic        key_flag,
    output filt_state_e state
);
    localparam int             FW       = cnt_width(CNT_FILT);
    localparam logic [FW-1:0]  FILT_MAX = FW'(CNT_FILT);

    logic          sync1_q, sync2_q;
    logic          key_s;
    filt_state_e   state_q, state_d;
    logic [FW-1:0] cnt_f_q, cnt_f_d;
    logic          flag_q, flag_d;

    assign key_s = sync2_q;

    // Synchronise the raw key; idle level (released) is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
        end
    end

    // Filter state, window counter and press flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_f_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_f_q <= cnt_f_d;
            flag_q  <= flag_d;
        end
    end

    // Next state: a level must hold for the whole window to be accepted;
    // any sample of the opposite level abandons the window.
    always_comb begin
        state_d = state_q;
        cnt_f_d = cnt_f_q;
        flag_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_f_d = '0;
                if (!key_s) state_d = FILT_DN;
            end
            FILT_DN: begin
                if (key_s) begin
                    state_d = IDLE;
                end else if (cnt_f_q == FILT_MAX) begin
                    state_d = HELD;
                    flag_d  = 1'b1;
                end else begin
                    cnt_f_d = cnt_f_q + 1'b1;
                end
            end
            HELD: begin
                cnt_f_d = '0;
                if (key_s) state_d = FILT_UP;
            end
            FILT_UP: begin
                if (!key_s) begin
                    state_d = HELD;
                end else if (cnt_f_q == FILT_MAX) begin
                    state_d = IDLE;
                end else begin
                    cnt_f_d = cnt_f_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_f_d = '0;
            end
        endcase
    end

    assign key_flag = flag_q;
    assign state    = state_q;

endmodule

// File: rtl/key_step_sel.sv
// 3-bit select generator for a 3-to-8 decoder: the index advances on each
// debounced press or on each auto-step tick; {a,b,c} = index, a is the MSB.
module key_step_sel
    import key_step_pkg::*;
#(
    parameter int CNT_FILT = CNT_FILT_50M,
    parameter int CNT_STEP = CNT_STEP_50M
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    key_step_sel_if.slave  bus
);
    localparam int            SW       = cnt_width(CNT_STEP);
    localparam logic [SW-1:0] STEP_MAX = SW'(CNT_STEP);

    logic          key_flag;
    filt_state_e   filt_state;
    logic          tick;
    logic [SW-1:0] cnt_s_q, cnt_s_d;
    logic [2:0]    idx_q, idx_d;
    logic          step_q, step_d;

    key_filter #(.CNT_FILT(CNT_FILT)) u_key_filter (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .key_in   (bus.key_in),
        .key_flag (key_flag),
        .state    (filt_state)
    );

    // Tick is gated by auto_en so dropping it suppresses a tick at once.
    assign tick = bus.auto_en && (cnt_s_q == STEP_MAX);

    // Prescaler restarts on disable, on its own tick and on a key step;
    // the index takes one step even when key and tick coincide.
    always_comb begin
        cnt_s_d = cnt_s_q + 1'b1;
        idx_d   = idx_q;
        step_d  = key_flag || tick;
        if (!bus.auto_en || tick || key_flag) cnt_s_d = '0;
        if (key_flag || tick) idx_d = idx_q + 3'd1;
    end

    // Prescaler, index and step pulse registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_s_q <= '0;
            idx_q   <= 3'd0;
            step_q  <= 1'b0;
        end else begin
            cnt_s_q <= cnt_s_d;
            idx_q   <= idx_d;
            step_q  <= step_d;
        end
    end

    assign bus.a          = idx_q[2];
    assign bus.b          = idx_q[1];
    assign bus.c          = idx_q[0];
    assign bus.key_flag   = key_flag;
    assign bus.step       = step_q;
    assign bus.filt_state = filt_state;

endmodule
